mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: none; all widths fixed (32-bit address and data, 8-bit mem_control).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_valid  in  1  pipeline presents a memory op this cycle.
REQ-005 mem_control  in  8  one-hot op, MSB->LSB {lb,lbu,lh,lhu,lw,sb,sh,sw}; multiple bits set: highest bit wins.
REQ-006 mem_addr  in  32  effective address; mem_wdata  in  32  rt value for stores.
REQ-007 flush  in  1  discard current op (exception/eret from later stage).
REQ-008 lsu_stall  out  1  pipeline must hold the memory stage this cycle.
REQ-009 done  out  1  one-cycle pulse: op complete; ld_valid  out  1  done for a load; ld_data  out  32  extended load result.
REQ-010 data_sram_req/wr  out  1 each; data_sram_size  out  2 (0 byte, 1 half, 2 word); data_sram_addr  out  32; data_sram_wstrb  out  4; data_sram_wdata  out  32.
REQ-011 data_sram_addr_ok, data_sram_data_ok  in  1 each; data_sram_rdata  in  32.
REQ-012 adel, ades  out  1 each  address-error pulses; badvaddr  out  32  faulting address.

Function
REQ-013 FSM states IDLE, REQ, WAIT, DROP, DONE; all sram-side outputs driven from registered state/latches.
REQ-014 IDLE: mem_valid & any mem_control bit & !flush -> latch op/addr/wdata, go REQ; lsu_stall=1 that cycle.
REQ-015 REQ: data_sram_req=1, fields stable until addr_ok; addr_ok -> WAIT; flush before addr_ok -> IDLE, no transfer.
REQ-016 WAIT: req=0; data_ok -> capture rdata, go DONE; flush in WAIT -> DROP.
REQ-017 DROP: wait for data_ok, discard data, no done pulse, -> IDLE; addr_ok/data_ok while IDLE ignored.
REQ-018 DONE: done=1 one cycle, ld_valid=1 for loads, lsu_stall=0, -> IDLE; new op may be accepted next cycle.
REQ-019 lsu_stall=1 in IDLE-accept, REQ, WAIT, DROP; 0 otherwise.
REQ-020 Minimum latency: accept T, req T+1, addr_ok T+1, data_ok T+2, done T+3.
REQ-021 Stores: sb wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}; sh wstrb=addr[1]?1100:0011, wdata={2{wdata[15:0]}}; sw wstrb=1111; wr=1.
REQ-022 Loads: wr=0, wstrb=0000; lb/lbu select byte addr[1:0], lh/lhu select half addr[1], sign-extend lb/lh, zero-extend lbu/lhu, lw unmodified.
REQ-023 data_sram_addr = latched address after alignment rule of REQ-027/028.
REQ-024 ld_data holds last load value until next load completes; done/ld_valid never both with flush-dropped op.

Reset
REQ-025 rst -> state IDLE, req=0, wr=0, wstrb=0, size=0, addr=0, wdata=0, done=0, ld_valid=0, ld_data=0, lsu_stall=0, adel=ades=0, badvaddr=0.
REQ-026 rst mid-transaction abandons op; any later data_ok before a new req is ignored.

Configuration
REQ-027 UNALIGNED_EXC_EN defined: lh/lhu with addr[0]=1 or lw with addr[1:0]!=0 -> no request, adel=1 and done=1 next cycle, badvaddr=addr; sh/sw likewise -> ades; flush same cycle suppresses pulse.
REQ-028 UNALIGNED_EXC_EN undefined: adel=ades=0 and badvaddr=0 constantly; address forced aligned (half clears bit0, word clears bits1:0) and op proceeds.

Verification
REQ-029 lb at 0x1003, rdata=0x80AA_BBCC, addr_ok/data_ok immediate -> req T+1 size=0, done T+3, ld_data=0xFFFFFF80; lbu -> 0x00000080.
REQ-030 sh at 0x2002, wdata=0x1234_5678 -> wstrb=1100, sram wdata=0x5678_5678, wr=1, done without ld_valid.
REQ-031 addr_ok held low 5 cycles -> req and fields stable 5 cycles, lsu_stall high throughout.
REQ-032 flush in WAIT for lw -> no done, data_ok later absorbed in DROP, next op's request issues after.
REQ-033 lw at 0x3001 with UNALIGNED_EXC_EN -> no req, adel=1, badvaddr=0x3001; without macro -> req addr=0x3000.
REQ-034 rst asserted in REQ -> req=0 next cycle, all outputs at reset values, stray data_ok ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit sitting between the pipeline memory stage and a
//   request/address-ok/data-ok style data SRAM port. One op in flight.
//
//   Optional feature macro: UNALIGNED_EXC_EN
//     defined   : misaligned half/word accesses raise adel/ades, no SRAM request
//     undefined : misaligned addresses are force-aligned and the op proceeds
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     mem_valid, mem_control[7:0]   op strobe, one-hot {lb,lbu,lh,lhu,lw,sb,sh,sw}
//     mem_addr[31:0], mem_wdata     effective address, store data
//     flush                         discard the current op
//     lsu_stall                     hold the memory stage
//     done, ld_valid, ld_data       completion pulse, load flag, extended load data
//     data_sram_*                   SRAM request side (req/wr/size/addr/wstrb/wdata)
//     data_sram_addr_ok/data_ok/rdata  SRAM handshake and read data
//     adel, ades, badvaddr          address-error pulses and faulting address
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [7:0]  mem_control,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic        lsu_stall,
    output logic        done,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_DONE} state_t;

    state_t      state;
    logic        op_load;
    logic        op_signed;
    logic [1:0]  op_lo;

    logic        dec_load;
    logic        dec_signed;
    logic [1:0]  dec_size;
    logic        accept;
    logic [31:0] aligned_addr;

    function automatic logic [3:0] st_wstrb(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    return 4'b0001 << lo;
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] st_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ld_extract(input logic [1:0] sz, input logic sgn,
                                               input logic [1:0] lo, input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (sz)
            2'd0:    return sgn ? {{24{b[7]}}, b} : {24'b0, b};
            2'd1:    return sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: return rd;
        endcase
    endfunction

    // Priority decode: the highest set bit of mem_control selects the op.
    always_comb begin
        dec_load   = 1'b0;
        dec_signed = 1'b0;
        dec_size   = 2'd2;
        if (mem_control[7])      begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 2'd0; end
        else if (mem_control[6]) begin dec_load = 1'b1; dec_size = 2'd0; end
        else if (mem_control[5]) begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 2'd1; end
        else if (mem_control[4]) begin dec_load = 1'b1; dec_size = 2'd1; end
        else if (mem_control[3]) begin dec_load = 1'b1; dec_size = 2'd2; end
        else if (mem_control[2]) begin dec_size = 2'd0; end
        else if (mem_control[1]) begin dec_size = 2'd1; end
        else                     begin dec_size = 2'd2; end
    end

    assign accept = (state == S_IDLE) && mem_valid && (|mem_control) && !flush;

    always_comb begin
        aligned_addr = mem_addr;
        if (dec_size == 2'd1)      aligned_addr[0]   = 1'b0;
        else if (dec_size == 2'd2) aligned_addr[1:0] = 2'b00;
    end

    assign lsu_stall = accept || (state == S_REQ) || (state == S_WAIT) || (state == S_DROP);

`ifdef UNALIGNED_EXC_EN
    logic misalign;
    assign misalign = (dec_size == 2'd1 && mem_addr[0]) ||
                      (dec_size == 2'd2 && mem_addr[1:0] != 2'b00);
`else
    assign adel     = 1'b0;
    assign ades     = 1'b0;
    assign badvaddr = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            op_load         <= 1'b0;
            op_signed       <= 1'b0;
            op_lo           <= 2'd0;
            data_sram_req   <= 1'b0;
            data_sram_wr    <= 1'b0;
            data_sram_size  <= 2'd0;
            data_sram_addr  <= 32'd0;
            data_sram_wstrb <= 4'd0;
            data_sram_wdata <= 32'd0;
            done            <= 1'b0;
            ld_valid        <= 1'b0;
            ld_data         <= 32'd0;
`ifdef UNALIGNED_EXC_EN
            adel            <= 1'b0;
            ades            <= 1'b0;
            badvaddr        <= 32'd0;
`endif
        end else begin
            done     <= 1'b0;
            ld_valid <= 1'b0;
`ifdef UNALIGNED_EXC_EN
            adel     <= 1'b0;
            ades     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_load         <= dec_load;
                        op_signed       <= dec_signed;
                        op_lo           <= mem_addr[1:0];
                        data_sram_wr    <= !dec_load;
                        data_sram_size  <= dec_size;
                        data_sram_addr  <= aligned_addr;
                        data_sram_wstrb <= dec_load ? 4'b0000 : st_wstrb(dec_size, mem_addr[1:0]);
                        data_sram_wdata <= dec_load ? 32'd0 : st_wdata(dec_size, mem_wdata);
`ifdef UNALIGNED_EXC_EN
                        if (misalign) begin
                            // Fault completes without touching the SRAM.
                            done     <= 1'b1;
                            adel     <= dec_load;
                            ades     <= !dec_load;
                            badvaddr <= mem_addr;
                            state    <= S_DONE;
                        end else begin
                            data_sram_req <= 1'b1;
                            state         <= S_REQ;
                        end
`else
                        data_sram_req <= 1'b1;
                        state         <= S_REQ;
`endif
                    end
                end
                S_REQ: begin
                    if (data_sram_addr_ok) begin
                        // Once the address is taken the data beat must be absorbed.
                        data_sram_req <= 1'b0;
                        state         <= flush ? S_DROP : S_WAIT;
                    end else if (flush) begin
                        data_sram_req <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (data_sram_data_ok) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            if (op_load)
                                ld_data <= ld_extract(data_sram_size, op_signed, op_lo, data_sram_rdata);
                            done     <= 1'b1;
                            ld_valid <= op_load;
                            state    <= S_DONE;
                        end
                    end else if (flush) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (data_sram_data_ok) state <= S_IDLE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [7:0]  mem_control;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        lsu_stall;
    logic        done;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_control(mem_control),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush),
        .lsu_stall(lsu_stall), .done(done), .ld_valid(ld_valid), .ld_data(ld_data),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .adel(adel), .ades(ades), .badvaddr(badvaddr)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] LB = 8'h80, LBU = 8'h40, LH = 8'h20, LHU = 8'h10, LW = 8'h08;
    localparam logic [7:0] SB = 8'h04, SH = 8'h02, SW = 8'h01;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        ldv;
        logic [31:0] ldd;
        logic        adel;
        logic        ades;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [3:0] ws, input logic [31:0] wd);
        req_t r;
        r.wr = wr; r.size = sz; r.addr = a; r.wstrb = ws; r.wdata = wd;
        req_q.push_back(r);
    endtask

    task automatic exp_resp(input logic ldv, input logic [31:0] ldd, input logic el, input logic es);
        resp_t r;
        r.ldv = ldv; r.ldd = ldd; r.adel = el; r.ades = es;
        resp_q.push_back(r);
    endtask

    // Scoreboard monitor: SRAM handshakes and completion pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_sram_req && data_sram_addr_ok) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_addr", data_sram_addr, r.addr);
                    chk("req_wdata", data_sram_wdata, r.wdata);
                    chk("req_wr_size_wstrb", {25'd0, data_sram_wr, data_sram_size, data_sram_wstrb},
                        {25'd0, r.wr, r.size, r.wstrb});
                end
            end
            if (done) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    resp_t p;
                    p = resp_q.pop_front();
                    chk("resp_ld_valid", {31'd0, ld_valid}, {31'd0, p.ldv});
                    chk("resp_ld_data", ld_data, p.ldd);
                    chk("resp_adel_ades", {30'd0, adel, ades}, {30'd0, p.adel, p.ades});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op with a cooperative SRAM: addr_ok after aok_dly cycles, data_ok right after.
    task automatic run_op(input logic [7:0] ctrl, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int aok_dly);
        logic [31:0] first_addr;
        mem_valid = 1'b1; mem_control = ctrl; mem_addr = a; mem_wdata = wd;
        @(negedge clk);
        chk("stall_accept", {31'd0, lsu_stall}, 32'd1);
        tick();
        mem_valid = 1'b0; mem_control = 8'h00;
        @(negedge clk);
        chk("req_t1", {31'd0, data_sram_req}, 32'd1);
        first_addr = data_sram_addr;
        for (int i = 0; i < aok_dly; i++) begin
            @(negedge clk);
            chk("req_hold", {31'd0, data_sram_req}, 32'd1);
            chk("addr_hold", data_sram_addr, first_addr);
            chk("stall_hold", {31'd0, lsu_stall}, 32'd1);
            tick();
        end
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        @(negedge clk);
        chk("wait_req_low", {30'd0, data_sram_req, done}, 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("done_pulse", {30'd0, done, lsu_stall}, 32'd2);
        tick();
        @(negedge clk);
        chk("done_cleared", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_control = 8'h00; mem_addr = 32'd0; mem_wdata = 32'd0;
        flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ctrl", {23'd0, lsu_stall, done, ld_valid, data_sram_req, data_sram_wr,
                         data_sram_size, adel, ades}, 32'd0);
        chk("rst_addr_wstrb", data_sram_addr | {28'd0, data_sram_wstrb}, 32'd0);
        chk("rst_data", data_sram_wdata | ld_data | badvaddr, 32'd0);
        rst = 1'b0;
        tick();

        // lb / lbu at 0x1003, top byte 0x80
        exp_req(1'b0, 2'd0, 32'h1003, 4'b0000, 32'd0);
        exp_resp(1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
        run_op(LB, 32'h1003, 32'd0, 32'h80AA_BBCC, 0);
        exp_req(1'b0, 2'd0, 32'h1003, 4'b0000, 32'd0);
        exp_resp(1'b1, 32'h0000_0080, 1'b0, 1'b0);
        run_op(LBU, 32'h1003, 32'd0, 32'h80AA_BBCC, 0);

        // sh upper half; ld_data keeps the previous load
        exp_req(1'b1, 2'd1, 32'h2002, 4'b1100, 32'h5678_5678);
        exp_resp(1'b0, 32'h0000_0080, 1'b0, 1'b0);
        run_op(SH, 32'h2002, 32'h1234_5678, 32'd0, 0);

        // sw with addr_ok held off 5 cycles
        exp_req(1'b1, 2'd2, 32'h4000, 4'b1111, 32'hDEAD_BEEF);
        exp_resp(1'b0, 32'h0000_0080, 1'b0, 1'b0);
        run_op(SW, 32'h4000, 32'hDEAD_BEEF, 32'd0, 5);

        // halfword loads, word load, byte store
        exp_req(1'b0, 2'd1, 32'h5002, 4'b0000, 32'd0);
        exp_resp(1'b1, 32'hFFFF_8001, 1'b0, 1'b0);
        run_op(LH, 32'h5002, 32'd0, 32'h8001_7FFF, 1);
        exp_req(1'b0, 2'd1, 32'h5000, 4'b0000, 32'd0);
        exp_resp(1'b1, 32'h0000_F00D, 1'b0, 1'b0);
        run_op(LHU, 32'h5000, 32'd0, 32'h8001_F00D, 0);
        exp_req(1'b0, 2'd2, 32'h6004, 4'b0000, 32'd0);
        exp_resp(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        run_op(LW, 32'h6004, 32'd0, 32'h1234_5678, 0);
        exp_req(1'b1, 2'd0, 32'h7001, 4'b0010, 32'hABAB_ABAB);
        exp_resp(1'b0, 32'h1234_5678, 1'b0, 1'b0);
        run_op(SB, 32'h7001, 32'h0000_00AB, 32'd0, 0);

        // lw and sw both set: lw wins
        exp_req(1'b0, 2'd2, 32'h8000, 4'b0000, 32'd0);
        exp_resp(1'b1, 32'hCAFE_BABE, 1'b0, 1'b0);
        run_op(LW | SW, 32'h8000, 32'h1111_1111, 32'hCAFE_BABE, 0);

        // flush in WAIT: address taken, data absorbed in DROP, no completion
        exp_req(1'b0, 2'd2, 32'h9000, 4'b0000, 32'd0);
        mem_valid = 1'b1; mem_control = LW; mem_addr = 32'h9000;
        tick();
        mem_valid = 1'b0; mem_control = 8'h00;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drop_stall", {30'd0, lsu_stall, done}, 32'd2);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_BAD0;
        tick();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("drop_exit", {29'd0, lsu_stall, done, ld_valid}, 32'd0);
        chk("drop_ld_hold", ld_data, 32'hCAFE_BABE);
        exp_req(1'b0, 2'd0, 32'h9001, 4'b0000, 32'd0);
        exp_resp(1'b1, 32'h0000_00AA, 1'b0, 1'b0);
        run_op(LBU, 32'h9001, 32'd0, 32'h0000_AA00, 0);

        // flush in REQ before addr_ok: request withdrawn, back to idle
        mem_valid = 1'b1; mem_control = SW; mem_addr = 32'hA000; mem_wdata = 32'h5;
        tick();
        mem_valid = 1'b0; mem_control = 8'h00;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("req_flush", {29'd0, data_sram_req, lsu_stall, done}, 32'd0);
        tick();

        // misaligned word load at 0x3001
`ifdef UNALIGNED_EXC_EN
        exp_resp(1'b0, 32'h0000_00AA, 1'b1, 1'b0);
        mem_valid = 1'b1; mem_control = LW; mem_addr = 32'h3001;
        tick();
        mem_valid = 1'b0; mem_control = 8'h00;
        @(negedge clk);
        chk("misalign_noreq", {30'd0, data_sram_req, done}, 32'd1);
        chk("misalign_badvaddr", badvaddr, 32'h3001);
        tick();
        @(negedge clk);
        chk("misalign_pulse_end", {30'd0, adel, done}, 32'd0);
        tick();
        exp_resp(1'b0, 32'h0000_00AA, 1'b0, 1'b1);
        mem_valid = 1'b1; mem_control = SW; mem_addr = 32'h3002;
        tick();
        mem_valid = 1'b0; mem_control = 8'h00;
        @(negedge clk);
        chk("misalign_st_badvaddr", badvaddr, 32'h3002);
        tick();
        tick();
`else
        exp_req(1'b0, 2'd2, 32'h3000, 4'b0000, 32'd0);
        exp_resp(1'b1, 32'h5566_7788, 1'b0, 1'b0);
        run_op(LW, 32'h3001, 32'd0, 32'h5566_7788, 0);
        exp_req(1'b1, 2'd2, 32'h3000, 4'b1111, 32'h0102_0304);
        exp_resp(1'b0, 32'h5566_7788, 1'b0, 1'b0);
        run_op(SW, 32'h3002, 32'h0102_0304, 32'd0, 0);
        @(negedge clk);
        chk("noexc_badvaddr", badvaddr | {30'd0, adel, ades}, 32'd0);
`endif

        // reset while in REQ, then a stray data_ok
        mem_valid = 1'b1; mem_control = SW; mem_addr = 32'h4444; mem_wdata = 32'h1;
        tick();
        mem_valid = 1'b0; mem_control = 8'h00;
        @(negedge clk);
        chk("pre_rst_req", {31'd0, data_sram_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctrl", {23'd0, lsu_stall, done, ld_valid, data_sram_req, data_sram_wr,
                             data_sram_size, adel, ades}, 32'd0);
        chk("mid_rst_data", ld_data | data_sram_addr | data_sram_wdata | badvaddr, 32'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFF_FFFF;
        tick();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("stray_data_ok", {29'd0, done, ld_valid, lsu_stall}, 32'd0);
        tick();
        exp_req(1'b0, 2'd0, 32'h1003, 4'b0000, 32'd0);
        exp_resp(1'b1, 32'h0000_0080, 1'b0, 1'b0);
        run_op(LBU, 32'h1003, 32'd0, 32'h80AA_BBCC, 0);

        repeat (2) tick();
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("resp_q_empty", resp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
